// File: rtl/regfile_pkg.sv
// Shared widths, counts and types for the register-file scoreboard.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_TAG_WIDTH  = 2;
    localparam int DEF_NUM_RD     = 3;
    localparam int DEF_NUM_WR     = 2;
    localparam int DEF_NUM_CLR    = 3;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;
    typedef logic [DEF_TAG_WIDTH-1:0]  reg_tag_t;

endpackage

// File: rtl/regfile_entry.sv
// One architectural register: data, dirty bit and rename tag.
// Address decode is done by the parent; this module sees only hit strobes.
module regfile_entry
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int NUM_CLR    = DEF_NUM_CLR
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             flush,
    input  logic                             alloc_hit,
    input  logic [NUM_CLR-1:0]               clr_hit,
    input  logic [NUM_WR-1:0]                wr_hit,
    input  logic [NUM_WR*TAG_WIDTH-1:0]      wr_tag,
    input  logic [NUM_WR*DATA_WIDTH-1:0]     wr_data,
    output logic [DATA_WIDTH-1:0]            data,
    output logic                             dirty,
    output logic [TAG_WIDTH-1:0]             tag
);

    logic [DATA_WIDTH-1:0] data_d;
    logic                  dirty_d;
    logic [TAG_WIDTH-1:0]  tag_d;
    logic                  tag_match;

    // Next-state: highest write port wins the data; dirty follows flush > alloc > clear > tag-matched write.
    always_comb begin
        data_d    = data;
        tag_match = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_hit[i]) begin
                data_d = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                if (wr_tag[i*TAG_WIDTH +: TAG_WIDTH] == tag) begin
                    tag_match = 1'b1;
                end
            end
        end

        if (flush) begin
            dirty_d = 1'b0;
        end else if (alloc_hit) begin
            dirty_d = 1'b1;
        end else if (|clr_hit) begin
            dirty_d = 1'b0;
        end else if (tag_match) begin
            dirty_d = 1'b0;
        end else begin
            dirty_d = dirty;
        end

        // Flush only suppresses the dirty set; the tag still advances.
        tag_d = alloc_hit ? tag + TAG_WIDTH'(1) : tag;
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data  <= '0;
            dirty <= 1'b0;
            tag   <= '0;
        end else begin
            data  <= data_d;
            dirty <= dirty_d;
            tag   <= tag_d;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register dirty bit and rename tag.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
// Interface: no handshake; every alloc/clear/write/read request is accepted
// every cycle, state updates land on the next rising edge, reads are combinational.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter int NUM_CLR    = DEF_NUM_CLR
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic                          alloc_en,
    input  logic [ADDR_WIDTH-1:0]         alloc_addr,
    output logic [TAG_WIDTH-1:0]          alloc_tag,
    input  logic [NUM_CLR-1:0]            clr_en,
    input  logic [NUM_CLR*ADDR_WIDTH-1:0] clr_addr,
    input  logic [NUM_WR-1:0]             wr_en,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]  wr_addr,
    input  logic [NUM_WR*TAG_WIDTH-1:0]   wr_tag,
    input  logic [NUM_WR*DATA_WIDTH-1:0]  wr_data,
    input  logic [NUM_RD-1:0]             rd_en,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]             rd_dirty,
    output logic [NUM_RD*TAG_WIDTH-1:0]   rd_tag
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] ent_data  [DEPTH];
    logic                  ent_dirty [DEPTH];
    logic [TAG_WIDTH-1:0]  ent_tag   [DEPTH];

    // Register 0 is hardwired and has no storage.
    assign ent_data[0]  = '0;
    assign ent_dirty[0] = 1'b0;
    assign ent_tag[0]   = '0;

    for (genvar r = 1; r < DEPTH; r++) begin : g_entry
        logic [NUM_WR-1:0]  wr_hit;
        logic [NUM_CLR-1:0] clr_hit;

        for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_dec
            assign wr_hit[i] = wr_en[i] && (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r));
        end
        for (genvar j = 0; j < NUM_CLR; j++) begin : g_clr_dec
            assign clr_hit[j] = clr_en[j] && (clr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r));
        end

        regfile_entry #(
            .DATA_WIDTH (DATA_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .NUM_WR     (NUM_WR),
            .NUM_CLR    (NUM_CLR)
        ) u_entry (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush),
            .alloc_hit (alloc_en && (alloc_addr == ADDR_WIDTH'(r))),
            .clr_hit   (clr_hit),
            .wr_hit    (wr_hit),
            .wr_tag    (wr_tag),
            .wr_data   (wr_data),
            .data      (ent_data[r]),
            .dirty     (ent_dirty[r]),
            .tag       (ent_tag[r])
        );
    end

    // Tag the pending allocation will receive; register 0 never allocates.
    always_comb begin
        if (alloc_addr == '0) begin
            alloc_tag = '0;
        end else begin
            alloc_tag = ent_tag[alloc_addr] + TAG_WIDTH'(alloc_en);
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] sel_data;
        logic                  sel_dirty;

        assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Read mux, optionally overridden by the highest matching same-cycle write.
        always_comb begin
            sel_data  = ent_data[addr];
            sel_dirty = ent_dirty[addr];
`ifdef REGFILE_BYPASS_EN
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_en[i] && (addr != '0) &&
                    (wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
                    sel_data  = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                    sel_dirty = ent_dirty[addr] &&
                                (wr_tag[i*TAG_WIDTH +: TAG_WIDTH] != ent_tag[addr]);
                end
            end
`endif
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_en[k] ? sel_data : '0;
        assign rd_dirty[k]                         = rd_en[k] & sel_dirty;
        assign rd_tag[k*TAG_WIDTH +: TAG_WIDTH]    = ent_tag[addr];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard (default widths and port counts).
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int DW = DEF_DATA_WIDTH;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int TW = DEF_TAG_WIDTH;
    localparam int NR = DEF_NUM_RD;
    localparam int NW = DEF_NUM_WR;
    localparam int NC = DEF_NUM_CLR;

    logic              clk;
    logic              reset_n;
    logic              flush;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [TW-1:0]     alloc_tag;
    logic [NC-1:0]     clr_en;
    logic [NC*AW-1:0]  clr_addr;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*TW-1:0]  wr_tag;
    logic [NW*DW-1:0]  wr_data;
    logic [NR-1:0]     rd_en;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_dirty;
    logic [NR*TW-1:0]  rd_tag;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_tag  (alloc_tag),
        .clr_en     (clr_en),
        .clr_addr   (clr_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_tag     (wr_tag),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        clr_en     = '0;
        clr_addr   = '0;
        wr_en      = '0;
        wr_addr    = '0;
        wr_tag     = '0;
        wr_data    = '0;
        rd_en      = '0;
        rd_addr    = '0;
    endtask

    // Advance past the next rising edge; inputs driven after this are stable before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input int port, input int addr, input int tag, input logic [31:0] data);
        wr_en[port]                = 1'b1;
        wr_addr[port*AW +: AW]     = AW'(addr);
        wr_tag[port*TW +: TW]      = TW'(tag);
        wr_data[port*DW +: DW]     = data;
    endtask

    task automatic drive_rd(input int port, input int addr, input logic en);
        rd_en[port]            = en;
        rd_addr[port*AW +: AW] = AW'(addr);
    endtask

    // Read one register on port 0 and compare all three outputs.
    task automatic read_check(input string name, input int addr,
                              input logic [31:0] exp_data, input logic exp_dirty, input int exp_tag);
        drive_rd(0, addr, 1'b1);
        #1;
        check({name, "_data"},  rd_data[0 +: DW], exp_data);
        check({name, "_dirty"}, 32'(rd_dirty[0]), 32'(exp_dirty));
        check({name, "_tag"},   32'(rd_tag[0 +: TW]), 32'(exp_tag));
        drive_rd(0, 0, 1'b0);
    endtask

    initial begin
        idle_inputs();
        reset_n = 1'b0;
        #12;
        check("reset_rd_data", rd_data[0 +: DW], 32'h0);
        reset_n = 1'b1;
        tick();

        // Reset state read on every port
        for (int k = 0; k < NR; k++) drive_rd(k, 5, 1'b1);
        #1;
        for (int k = 0; k < NR; k++) begin
            check($sformatf("r5_p%0d_data", k),  rd_data[k*DW +: DW], 32'h0);
            check($sformatf("r5_p%0d_dirty", k), 32'(rd_dirty[k]), 32'h0);
            check($sformatf("r5_p%0d_tag", k),   32'(rd_tag[k*TW +: TW]), 32'h0);
        end
        idle_inputs();

        // Allocate r7, then retire it with a matching-tag write
        alloc_en = 1'b1; alloc_addr = 7;
        #1;
        check("alloc_tag_r7", 32'(alloc_tag), 32'd1);
        tick();
        idle_inputs();
        read_check("r7_alloc", 7, 32'h0, 1'b1, 1);
        drive_wr(0, 7, 1, 32'hDEADBEEF);
        tick();
        idle_inputs();
        read_check("r7_wb", 7, 32'hDEADBEEF, 1'b0, 1);

        // Stale-tag write to r3 leaves it dirty; a clear on port 2 cleans it
        alloc_en = 1'b1; alloc_addr = 3;
        tick();
        tick();
        idle_inputs();
        drive_wr(0, 3, 1, 32'h11);
        tick();
        idle_inputs();
        read_check("r3_stale", 3, 32'h11, 1'b1, 2);
        clr_en[2] = 1'b1; clr_addr[2*AW +: AW] = 3;
        tick();
        idle_inputs();
        read_check("r3_clr", 3, 32'h11, 1'b0, 2);

        // Same-address write collision: port 1 wins
        drive_wr(0, 9, 0, 32'hA);
        drive_wr(1, 9, 0, 32'hB);
        drive_rd(1, 9, 1'b1);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("r9_bypass", rd_data[1*DW +: DW], 32'hB);
`else
        check("r9_no_bypass", rd_data[1*DW +: DW], 32'h0);
`endif
        tick();
        idle_inputs();
        read_check("r9_collide", 9, 32'hB, 1'b0, 0);

        // Tag wrap on r4: 1, 2, 3, 0
        for (int n = 1; n <= 4; n++) begin
            alloc_en = 1'b1; alloc_addr = 4;
            tick();
            idle_inputs();
            read_check($sformatf("r4_alloc%0d", n), 4, 32'h0, 1'b1, n % 4);
        end
        // Alloc with flush: dirty suppressed, tag still advances
        alloc_en = 1'b1; alloc_addr = 4; flush = 1'b1;
        #1;
        check("alloc_tag_r4_flush", 32'(alloc_tag), 32'd1);
        tick();
        idle_inputs();
        read_check("r4_flush", 4, 32'h0, 1'b0, 1);

        // Register 0 ignores writes and allocations
        drive_wr(0, 0, 0, 32'hFF);
        alloc_en = 1'b1; alloc_addr = 0;
        #1;
        check("alloc_tag_r0", 32'(alloc_tag), 32'd0);
        tick();
        idle_inputs();
        read_check("r0", 0, 32'h0, 1'b0, 0);

        // Disabled read port gates data and dirty but not tag
        alloc_en = 1'b1; alloc_addr = 7;
        tick();
        idle_inputs();
        drive_rd(2, 7, 1'b0);
        #1;
        check("r7_gated_data",  rd_data[2*DW +: DW], 32'h0);
        check("r7_gated_dirty", 32'(rd_dirty[2]), 32'h0);
        check("r7_gated_tag",   32'(rd_tag[2*TW +: TW]), 32'd2);
        idle_inputs();

        // Asynchronous reset mid-cycle clears state without waiting for a clock edge
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        drive_rd(0, 7, 1'b1);
        drive_rd(1, 3, 1'b1);
        #1;
        check("arst_r7_data",  rd_data[0 +: DW], 32'h0);
        check("arst_r7_tag",   32'(rd_tag[0 +: TW]), 32'h0);
        check("arst_r3_data",  rd_data[1*DW +: DW], 32'h0);
        check("arst_r3_dirty", 32'(rd_dirty[1]), 32'h0);
        idle_inputs();
        #10;
        reset_n = 1'b1;
        tick();
        read_check("post_rst_r9", 9, 32'h0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
